// File: rtl/scan_sel_gen_pkg.sv
// Shared definitions for the scan select generator: select width, line
// count and FSM state encodings, also used by the decoder-side logic.
package scan_sel_gen_pkg;

  localparam int SEL_W     = 3;
  localparam int NUM_LINES = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scan_next_idx.sv
// Combinational next-line search for the scan select generator.
//   nxt   : first set mask bit above cur, searching upward modulo NUM_LINES
//           (cur itself when it is the only set bit)
//   wrap  : the search went round, i.e. nxt <= cur
//   first : lowest set mask bit (0 when mask is empty)
module scan_next_idx
  import scan_sel_gen_pkg::*;
(
  input  logic [SEL_W-1:0]     cur,
  input  logic [NUM_LINES-1:0] mask,
  output logic [SEL_W-1:0]     nxt,
  output logic                 wrap,
  output logic [SEL_W-1:0]     first
);

  logic             found;
  logic [SEL_W-1:0] idx;

  // Upward circular search starting one above the current line.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    idx   = cur;
    for (int i = 1; i < NUM_LINES; i++) begin
      idx = cur + SEL_W'(i);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    wrap = (nxt <= cur);
  end

  // Priority search from the top down so the lowest set bit wins.
  always_comb begin
    first = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (mask[i]) first = SEL_W'(i);
    end
  end

endmodule

// File: rtl/scan_sel_gen.sv
// Scan select generator: steps a 3-bit select through all unmasked lines,
// holding each line for DWELL cycles, with a registered valid and a
// one-cycle frame_done pulse on the first cycle after the scan wraps.
// Optional feature macro: BLANK_GAP_EN inserts a one-cycle blank
// (sel_valid=0, sel held) between consecutive selects.
//
// Output semantics: sel is only meaningful while sel_valid=1; downstream
// logic gates the decoder with sel_valid. There is no backpressure.
module scan_sel_gen
  import scan_sel_gen_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_LINES-1:0] mask,
  output logic [SEL_W-1:0]     sel,
  output logic                 sel_valid,
  output logic                 frame_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             fd_q, fd_d;

  logic [SEL_W-1:0] nxt_idx;
  logic [SEL_W-1:0] first_idx;
  logic             nxt_wrap;
  logic             go;

`ifdef BLANK_GAP_EN
  // Pending select captured on the advance edge, loaded after the blank.
  logic [SEL_W-1:0] pend_q, pend_d;
  logic             pend_wrap_q, pend_wrap_d;
`endif

  scan_next_idx u_next (
    .cur   (sel_q),
    .mask  (mask),
    .nxt   (nxt_idx),
    .wrap  (nxt_wrap),
    .first (first_idx)
  );

  assign go = en && (mask != '0);

  // Next-state, dwell counter and output-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    fd_d    = 1'b0;
`ifdef BLANK_GAP_EN
    pend_d      = pend_q;
    pend_wrap_d = pend_wrap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        cnt_d   = '0;
        if (go) begin
          state_d = ST_SCAN;
          sel_d   = first_idx;
          valid_d = 1'b1;
        end
      end
      ST_SCAN: begin
        if (!go) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
`ifdef BLANK_GAP_EN
          state_d     = ST_BLANK;
          valid_d     = 1'b0;
          pend_d      = nxt_idx;
          pend_wrap_d = nxt_wrap;
`else
          sel_d = nxt_idx;
          fd_d  = nxt_wrap;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef BLANK_GAP_EN
      ST_BLANK: begin
        cnt_d = '0;
        if (!go) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = ST_SCAN;
          sel_d   = pend_q;
          valid_d = 1'b1;
          fd_d    = pend_wrap_q;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      fd_q    <= fd_d;
    end
  end

`ifdef BLANK_GAP_EN
  // Pending-select registers used only across the blank cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      pend_wrap_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      pend_wrap_q <= pend_wrap_d;
    end
  end
`endif

  assign sel        = sel_q;
  assign sel_valid  = valid_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Self-checking bench for scan_sel_gen. Two instances (DWELL=4 and DWELL=1)
// share the stimulus. Expected per-cycle {sel, sel_valid, frame_done} comes
// from a closed-form model of the scan order (exp_at).
module tb_scan_sel_gen;

  localparam int DW_A = 4;
  localparam int DW_B = 1;
`ifdef BLANK_GAP_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] mask;
  logic [2:0] sel_a, sel_b;
  logic       valid_a, valid_b;
  logic       fd_a, fd_b;

  int n_vec = 0;
  int n_err = 0;

  logic [4:0] obs_a_q[$];
  logic [4:0] obs_b_q[$];
  logic [4:0] exp_q[$];
  logic [2:0] held_a, held_b;

  scan_sel_gen #(.DWELL(DW_A), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .mask(mask),
    .sel(sel_a), .sel_valid(valid_a), .frame_done(fd_a)
  );

  scan_sel_gen #(.DWELL(DW_B), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .mask(mask),
    .sel(sel_b), .sel_valid(valid_b), .frame_done(fd_b)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Expected {sel, valid, frame_done} at cycle k after enabling with mask m.
  function automatic logic [4:0] exp_at(input logic [7:0] m, input int dw, input int k);
    int lines[$];
    int c, p, d, r, kk;
    logic [2:0] s;
    logic v, f;
    for (int i = 0; i < 8; i++) if (m[i]) lines.push_back(i);
    c = lines.size();
    if (!BLANK || k < dw) begin
      p = k / dw;
      d = k % dw;
      s = 3'(lines[p % c]);
      v = 1'b1;
      f = (d == 0) && (p % c == 0) && (p > 0);
    end else begin
      kk = k - dw;
      p  = kk / (dw + 1) + 1;
      r  = kk % (dw + 1);
      if (r == 0) begin
        s = 3'(lines[(p - 1) % c]);
        v = 1'b0;
        f = 1'b0;
      end else begin
        s = 3'(lines[p % c]);
        v = 1'b1;
        f = (r == 1) && (p % c == 0);
      end
    end
    return {s, v, f};
  endfunction

  // Driver: reset pulse away from the clock edge
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    #2;
    rst = 1'b0;
    held_a = 3'd0;
    held_b = 3'd0;
  endtask

  // Driver: enable with mask m, record n scanning cycles; drop_kind 0 drops
  // en, 1 clears mask (one idle cycle recorded), 2 leaves the scan running.
  task automatic scan_obs(input logic [7:0] m, input int n, input int drop_kind);
    obs_a_q.delete();
    obs_b_q.delete();
    @(negedge clk);
    en   = 1'b1;
    mask = m;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      obs_a_q.push_back({sel_a, valid_a, fd_a});
      obs_b_q.push_back({sel_b, valid_b, fd_b});
    end
    if (drop_kind != 2) begin
      if (drop_kind == 0) en = 1'b0;
      else mask = 8'h00;
      @(negedge clk);
      obs_a_q.push_back({sel_a, valid_a, fd_a});
      obs_b_q.push_back({sel_b, valid_b, fd_b});
    end
  endtask

  // Driver: idle cycles with noise that must never start a scan
  task automatic idle_noise(input int n);
    obs_a_q.delete();
    obs_b_q.delete();
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        en = 1'b1; mask = 8'h00;
      end else begin
        en = 1'b0; mask = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      obs_a_q.push_back({sel_a, valid_a, fd_a});
      obs_b_q.push_back({sel_b, valid_b, fd_b});
    end
  endtask

  task automatic test_reset();
    logic [4:0] e;
    rst = 1'b1; en = 1'b0; mask = 8'h00;
    #12;
    rst = 1'b0;
    held_a = 3'd0; held_b = 3'd0;
    @(negedge clk);
    n_vec++;
    if ({sel_a, valid_a, fd_a} !== 5'd0) begin
      n_err++; $display("FAIL reset_a got %b exp %b", {sel_a, valid_a, fd_a}, 5'd0);
    end
    n_vec++;
    if ({sel_b, valid_b, fd_b} !== 5'd0) begin
      n_err++; $display("FAIL reset_b got %b exp %b", {sel_b, valid_b, fd_b}, 5'd0);
    end
    scan_obs(8'hFF, 7, 2);
    for (int k = 0; k < 7; k++) begin
      e = exp_at(8'hFF, DW_A, k);
      n_vec++;
      if (obs_a_q[k] !== e) begin
        n_err++; $display("FAIL prereset_a[%0d] got %b exp %b", k, obs_a_q[k], e);
      end
    end
    // Asynchronous reset mid-scan, checked before the next clock edge.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({sel_a, valid_a, fd_a} !== 5'd0) begin
      n_err++; $display("FAIL async_reset_a got %b exp %b", {sel_a, valid_a, fd_a}, 5'd0);
    end
    n_vec++;
    if ({sel_b, valid_b, fd_b} !== 5'd0) begin
      n_err++; $display("FAIL async_reset_b got %b exp %b", {sel_b, valid_b, fd_b}, 5'd0);
    end
    en = 1'b0;
    #2;
    rst = 1'b0;
    held_a = 3'd0; held_b = 3'd0;
  endtask

  task automatic test_scan_mask(input logic [7:0] m, input int n, input string name);
    logic [4:0] e;
    scan_obs(m, n, 0);
    for (int k = 0; k < n; k++) begin
      e = exp_at(m, DW_A, k);
      n_vec++;
      if (obs_a_q[k] !== e) begin
        n_err++; $display("FAIL %s_a[%0d] got %b exp %b", name, k, obs_a_q[k], e);
      end
      e = exp_at(m, DW_B, k);
      n_vec++;
      if (obs_b_q[k] !== e) begin
        n_err++; $display("FAIL %s_b[%0d] got %b exp %b", name, k, obs_b_q[k], e);
      end
    end
    e = exp_at(m, DW_A, n - 1);
    held_a = e[4:2];
    n_vec++;
    if (obs_a_q[n] !== {held_a, 2'b00}) begin
      n_err++; $display("FAIL %s_a_stop got %b exp %b", name, obs_a_q[n], {held_a, 2'b00});
    end
    e = exp_at(m, DW_B, n - 1);
    held_b = e[4:2];
    n_vec++;
    if (obs_b_q[n] !== {held_b, 2'b00}) begin
      n_err++; $display("FAIL %s_b_stop got %b exp %b", name, obs_b_q[n], {held_b, 2'b00});
    end
  endtask

  task automatic test_full_mask();
    int per;
    per = 8 * (DW_A + (BLANK ? 1 : 0));
    test_scan_mask(8'hFF, per + 6, "full");
    n_vec++;
    if (obs_a_q[per] !== {3'd0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL full_wrap got %b exp %b", obs_a_q[per], {3'd0, 1'b1, 1'b1});
    end
  endtask

  task automatic test_single_line();
    int ndrop;
    test_scan_mask(8'h10, 20, "single");
    ndrop = 0;
    for (int k = 0; k < 20; k++) if (obs_a_q[k][1] !== 1'b1) ndrop++;
    n_vec++;
    if (ndrop != (BLANK ? 4 : 0)) begin
      n_err++; $display("FAIL single_valid_drops got %0d exp %0d", ndrop, BLANK ? 4 : 0);
    end
  endtask

  task automatic test_en_toggle();
    int n;
    logic [4:0] e;
    n = BLANK ? 16 : 14;
    test_scan_mask(8'hFF, n, "entog");
    n_vec++;
    if (obs_a_q[n] !== {3'd3, 2'b00}) begin
      n_err++; $display("FAIL entog_hold3 got %b exp %b", obs_a_q[n], {3'd3, 2'b00});
    end
    scan_obs(8'hF0, 5, 0);
    n_vec++;
    if (obs_a_q[0] !== {3'd4, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL restart_sel4 got %b exp %b", obs_a_q[0], {3'd4, 1'b1, 1'b0});
    end
    for (int k = 0; k < 5; k++) begin
      e = exp_at(8'hF0, DW_B, k);
      n_vec++;
      if (obs_b_q[k] !== e) begin
        n_err++; $display("FAIL restart_b[%0d] got %b exp %b", k, obs_b_q[k], e);
      end
    end
    e = exp_at(8'hF0, DW_A, 4); held_a = e[4:2];
    e = exp_at(8'hF0, DW_B, 4); held_b = e[4:2];
  endtask

  task automatic test_mask_change();
    int total;
    exp_q.delete();
    for (int k = 0; k < 6; k++) exp_q.push_back(exp_at(8'hFF, DW_A, k));
    for (int k = 0; k < (BLANK ? 3 : 2); k++) exp_q.push_back({3'd1, 1'b1, 1'b0});
    if (BLANK) exp_q.push_back({3'd1, 1'b0, 1'b0});
    for (int k = 0; k < 4; k++) exp_q.push_back({3'd7, 1'b1, 1'b0});
    if (BLANK) exp_q.push_back({3'd7, 1'b0, 1'b0});
    exp_q.push_back({3'd0, 1'b1, 1'b1});
    for (int k = 0; k < 3; k++) exp_q.push_back({3'd0, 1'b1, 1'b0});
    total = exp_q.size();
    obs_a_q.delete();
    @(negedge clk);
    en = 1'b1; mask = 8'hFF;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      obs_a_q.push_back({sel_a, valid_a, fd_a});
      if (k == 5) mask = 8'h81;
    end
    en = 1'b0;
    @(negedge clk);
    obs_a_q.push_back({sel_a, valid_a, fd_a});
    exp_q.push_back({3'd0, 1'b0, 1'b0});
    for (int k = 0; k <= total; k++) begin
      n_vec++;
      if (obs_a_q[k] !== exp_q[k]) begin
        n_err++; $display("FAIL maskchg[%0d] got %b exp %b", k, obs_a_q[k], exp_q[k]);
      end
    end
    apply_reset();
  endtask

  task automatic test_random();
    logic [7:0] m;
    int n, dk, ni;
    logic [4:0] e;
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 3) == 0) m = 8'(1 << $urandom_range(0, 7));
      else m = 8'($urandom_range(1, 255));
      n  = $urandom_range(1, 50);
      dk = $urandom_range(0, 1);
      scan_obs(m, n, dk);
      for (int k = 0; k < n; k++) begin
        e = exp_at(m, DW_A, k);
        n_vec++;
        if (obs_a_q[k] !== e) begin
          n_err++; $display("FAIL rnd%0d_a[%0d] m=%h got %b exp %b", it, k, m, obs_a_q[k], e);
        end
        e = exp_at(m, DW_B, k);
        n_vec++;
        if (obs_b_q[k] !== e) begin
          n_err++; $display("FAIL rnd%0d_b[%0d] m=%h got %b exp %b", it, k, m, obs_b_q[k], e);
        end
      end
      e = exp_at(m, DW_A, n - 1); held_a = e[4:2];
      e = exp_at(m, DW_B, n - 1); held_b = e[4:2];
      n_vec++;
      if (obs_a_q[n] !== {held_a, 2'b00}) begin
        n_err++; $display("FAIL rnd%0d_a_stop got %b exp %b", it, obs_a_q[n], {held_a, 2'b00});
      end
      n_vec++;
      if (obs_b_q[n] !== {held_b, 2'b00}) begin
        n_err++; $display("FAIL rnd%0d_b_stop got %b exp %b", it, obs_b_q[n], {held_b, 2'b00});
      end
      ni = $urandom_range(1, 4);
      idle_noise(ni);
      for (int k = 0; k < ni; k++) begin
        n_vec++;
        if (obs_a_q[k] !== {held_a, 2'b00}) begin
          n_err++; $display("FAIL rnd%0d_a_idle[%0d] got %b exp %b", it, k, obs_a_q[k], {held_a, 2'b00});
        end
        n_vec++;
        if (obs_b_q[k] !== {held_b, 2'b00}) begin
          n_err++; $display("FAIL rnd%0d_b_idle[%0d] got %b exp %b", it, k, obs_b_q[k], {held_b, 2'b00});
        end
      end
      en = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_scan_mask(8'b1010_0100, 30, "sparse");
    test_single_line();
    test_en_toggle();
    test_mask_change();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
